// File: rtl/atconv_host.sv
// Host/memory responder for the ATCONV engine: image load, image/result memories, layer-1 drain.
// Optional ATCONV_HOST_BOUNDS_EN adds the sticky addr_err output and layer-1 range checking.
module atconv_host #(
    parameter int unsigned DW        = 13,
    parameter int unsigned IMG_DEPTH = 4096,
    parameter int unsigned L1_DEPTH  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          start,
    output logic          ready,
    input  logic          busy,
    input  logic [11:0]   iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          csel,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          done
`ifdef ATCONV_HOST_BOUNDS_EN
    ,
    output logic          addr_err
`endif
);
    localparam int unsigned LAW = $clog2(L1_DEPTH);
    localparam logic [11:0]    IMG_LAST = 12'(IMG_DEPTH - 1);
    localparam logic [LAW-1:0] L1_LAST  = LAW'(L1_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [DW-1:0]  img [IMG_DEPTH];
    logic [DW-1:0]  l0  [IMG_DEPTH];
    logic [DW-1:0]  l1  [L1_DEPTH];
    logic [11:0]    load_cnt;
    logic [LAW-1:0] drain_cnt;

    logic load_hs, load_end, drain_hs, drain_end, in_run;
    logic wr_en, rd_en, l1_wr_ok, l1_rd_ok;

    assign load_hs   = (state == LOAD) && load_valid;
    assign load_end  = load_hs && (load_cnt == IMG_LAST);
    assign drain_hs  = (state == DRAIN) && out_ready;
    assign drain_end = drain_hs && (drain_cnt == L1_LAST);
    assign in_run    = (state == RUN);
    assign wr_en     = in_run && cwr;
    assign rd_en     = in_run && crd;

`ifdef ATCONV_HOST_BOUNDS_EN
    assign l1_wr_ok = (caddr_wr < 12'(L1_DEPTH));
    assign l1_rd_ok = (caddr_rd < 12'(L1_DEPTH));
`else
    assign l1_wr_ok = 1'b1;
    assign l1_rd_ok = 1'b1;
`endif

    assign load_ready = (state == LOAD);
    assign ready      = (state == ARM);
    assign out_valid  = (state == DRAIN);
    assign out_data   = (state == DRAIN) ? l1[drain_cnt] : '0;
    assign out_last   = (state == DRAIN) && (drain_cnt == L1_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)     state_nx = LOAD;
            LOAD:    if (load_end)  state_nx = ARM;
            ARM:     if (busy)      state_nx = RUN;
            RUN:     if (!busy)     state_nx = DRAIN;
            DRAIN:   if (drain_end) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            load_cnt  <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            idata     <= '0;
            cdata_rd  <= '0;
        end else begin
            state <= state_nx;
            done  <= drain_end;
            if (state == IDLE && start)
                load_cnt <= '0;
            else if (load_hs)
                load_cnt <= load_cnt + 12'd1;
            if (in_run && !busy)
                drain_cnt <= '0;
            else if (drain_hs)
                drain_cnt <= drain_cnt + LAW'(1);
            if (state == ARM || state == RUN)
                idata <= img[iaddr];
            // Nonblocking read alongside the write below gives read-first on collisions.
            if (rd_en) begin
                if (!csel)
                    cdata_rd <= l0[caddr_rd];
                else
                    cdata_rd <= l1_rd_ok ? l1[caddr_rd[LAW-1:0]] : '0;
            end
        end
    end

    // Memories are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_hs)
            img[load_cnt] <= load_data;
        if (wr_en && !csel)
            l0[caddr_wr] <= cdata_wr;
        if (wr_en && csel && l1_wr_ok)
            l1[caddr_wr[LAW-1:0]] <= cdata_wr;
    end

`ifdef ATCONV_HOST_BOUNDS_EN
    logic err_set;
    assign err_set = (!in_run && (cwr || crd))
                   || (in_run && csel && ((cwr && !l1_wr_ok) || (crd && !l1_rd_ok)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            addr_err <= 1'b0;
        else
            addr_err <= err_set || (addr_err && !start);
    end
`endif

endmodule

// File: doc/atconv_host.md
Name: atconv_host

Overview:
Synthesizable host/memory responder for the ATCONV engine interface. It serves the other end of that protocol.
- Loads a 64x64 image from a stream.
- Raises `ready` and answers `iaddr` with `idata`.
- Owns the layer-0 and layer-1 result memories (`cwr`/`crd`/`csel`).
- After the engine drops `busy`, streams the 1024 layer-1 results out.
It sits between the system bus/stream and `ATCONV`.

Parameters:
- `DW`, 13, data width of image and result words.
- `IMG_DEPTH`, 4096, image and layer-0 entries.
- `L1_DEPTH`, 1024, layer-1 entries.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `load_valid` in 1: image word valid.
- `load_data` in `DW`: image word, raster order from address 0.
- `load_ready` out 1: host accepts image word.
- `start` in 1: one-cycle pulse, begin load sequence.
- `ready` out 1: image available, to `ATCONV.ready`.
- `busy` in 1: from `ATCONV.busy`.
- `iaddr` in 12: image read address.
- `idata` out `DW`: image read data.
- `cwr` in 1: result write strobe.
- `caddr_wr` in 12: result write address.
- `cdata_wr` in `DW`: result write data.
- `crd` in 1: result read strobe.
- `caddr_rd` in 12: result read address.
- `cdata_rd` out `DW`: result read data.
- `csel` in 1: bank select, 0 = layer0, 1 = layer1.
- `out_valid` out 1: layer-1 result word valid.
- `out_data` out `DW`: layer-1 result word.
- `out_ready` in 1: downstream accepts word.
- `out_last` out 1: marks word 1023.
- `done` out 1: one-cycle pulse after the last output handshake.

Behaviour:
- Reset (`reset` = 0, asynchronous): state IDLE.
  - All outputs are 0.
  - Load/drain counters are 0.
  - Memories are not cleared.
  - Reset mid-operation aborts to IDLE with the same values.
- States: IDLE, LOAD, ARM, RUN, DRAIN.
- IDLE:
  - `start` → LOAD, `load_ready` = 1 next cycle.
  - `start` in any other state is ignored.
- LOAD:
  - Word written to img[cnt] on `load_valid` & `load_ready`; cnt increments.
  - The handshake at cnt = 4095 → ARM; `load_ready` drops the same edge.
- ARM:
  - `ready` = 1.
  - `busy` sampled 1 → RUN; `ready` = 0 from the next cycle.
- RUN:
  - `busy` sampled 0 (having been 1) → DRAIN, drain cnt = 0.
- DRAIN:
  - `out_valid` = 1, `out_data` = L1[cnt], `out_last` = (cnt == 1023).
  - Data is held while `out_ready` = 0.
  - Handshake at 1023 → IDLE with `done` = 1 for one cycle.
- Image port (active in ARM and RUN): `idata` is registered, `idata` = img[`iaddr` sampled at posedge N], valid after posedge N. Outside ARM/RUN, `idata` holds its last value.
- Result write: on posedge with `cwr` = 1, `cdata_wr` is written to bank `csel` at `caddr_wr`.
- Result read: on posedge with `crd` = 1, `cdata_rd` = bank[`csel`][`caddr_rd`]. Otherwise `cdata_rd` holds.
- Read-during-write, same bank and address, same edge: read-first, so `cdata_rd` returns the old value.
- `cwr`/`crd` are honoured only in RUN; ignored elsewhere.
- Layer-1 addresses use `caddr[9:0]` (see optional feature for range handling).
- No arithmetic. All addresses wrap modulo their depth; the counters never exceed depth-1.

Optional Feature:
`ATCONV_HOST_BOUNDS_EN`
- Defined:
  - Adds output `addr_err` (1 bit, sticky, cleared only by reset or `start`).
  - A layer-1 access with `caddr` >= `L1_DEPTH` sets `addr_err`.
    - Such a write is dropped.
    - Such a read returns 0.
  - `cwr`/`crd` outside RUN also set `addr_err`.
- Undefined:
  - The `addr_err` port is absent.
  - Layer-1 address is truncated to 10 bits; no checking.

Test Plan:
- Reset mid-LOAD at word 100 → all outputs 0, state IDLE; a fresh `start` reloads from address 0.
- Load img[k] = k & 0x1FFF → `ready` = 1 exactly after handshake 4095. Then `iaddr` = 0x0A5 at edge N → `idata` = 0x0A5 after edge N.
- `busy` rises → `ready` = 0 on the following cycle. `cwr` = 1, `csel` = 0, `caddr_wr` = 4095, data 0x1ABC, then `crd` same address → `cdata_rd` = 0x1ABC.
- Same-edge `cwr` + `crd`: `csel` = 1, addr 5, old 0x0011, new 0x0022 → `cdata_rd` = 0x0011; next read gives 0x0022.
- Drain after `busy` falls, with `out_ready` toggled 1/0 every cycle → 1024 words in address order. `out_last` only on word 1023, `done` pulse once, held data stable while stalled.
- With `ATCONV_HOST_BOUNDS_EN`: write `csel` = 1 at addr 1024 → L1[0] unchanged, `addr_err` = 1 until `start`.
